// File: rtl/definitions_pkg.sv
// Shared definitions for the UART receive path: clock/baud constants and
// the deframer state encoding.
package definitions_pkg;

  localparam int CLOCK_RATE = 50_000_000;
  localparam int BAUD_RATE  = 115_200;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    BREAK  = 3'd4
  } rx_state_e;

endpackage : definitions_pkg

// File: rtl/uart_rx_deframer_if.sv
// Valid/ready byte stream leaving the UART deframer.
interface uart_rx_deframer_if #(
  parameter int DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);

endinterface : uart_rx_deframer_if

// File: rtl/uart_rx_deframer_fifo.sv
// Show-ahead synchronous FIFO for received bytes. A write into a full FIFO
// only lands when a read frees a slot in the same cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_wr, do_rd;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // Gated to zero when empty so the stale (unreset) storage never shows.
  assign rd_data = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

  // NOTE: storage carries no reset; only the pointers define what is valid,
  // which keeps the array a plain RAM without a reset network.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule : uart_rx_fifo

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: samples rx on rising baud edges, checks framing
// (plus even parity when UART_RX_PARITY_EN is defined) and queues bytes.
module uart_rx_deframer
  import definitions_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic baud,
  input  logic rx,
  uart_rx_deframer_if.master m_if,
  output logic frame_err,
  output logic overrun,
`ifdef UART_RX_PARITY_EN
  output logic parity_err,
`endif
  output logic busy
);

  localparam int CNT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_DATA   = DATA;
  localparam logic [2:0] S_PARITY = PARITY;
  localparam logic [2:0] S_STOP   = STOP;
  localparam logic [2:0] S_BREAK  = BREAK;

  logic                 baud_q;
  logic                 tick;
  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 push_q, push_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 fifo_empty, fifo_full, fifo_pop;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 parity_err_q, parity_err_d;
`endif

  assign tick = baud && !baud_q;

  // NOTE: every combinational output gets a default first, so no path
  // through the case statement can leave a latch behind.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rx) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
            par_bad_d = 1'b0;
`endif
          end
        end
        S_DATA: begin
          // LSB-first line order: the first data bit ends up at bit 0.
          shreg_d   = {rx, shreg_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
        S_PARITY: begin
`ifdef UART_RX_PARITY_EN
          par_bad_d = (rx != ^shreg_q);
`endif
          state_d = S_STOP;
        end
        S_STOP: begin
          if (rx) begin
            state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) parity_err_d = 1'b1;
            else           push_d       = 1'b1;
`else
            push_d = 1'b1;
`endif
          end else begin
            // A low stop bit wins over any parity verdict.
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
        S_BREAK: begin
          if (rx) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign fifo_pop  = m_if.m_valid && m_if.m_ready;
  assign overrun_d = push_q && fifo_full && !fifo_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_q      <= 1'b0;
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      baud_q      <= baud;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push_q),
    .wr_data (shreg_q),
    .rd_en   (m_if.m_ready),
    .rd_data (m_if.m_data),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign m_if.m_valid = !fifo_empty;
  assign frame_err    = frame_err_q;
  assign overrun      = overrun_q;
  assign busy         = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err   = parity_err_q;
`endif

endmodule : uart_rx_deframer

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Sits directly downstream of the UART input synchronizer. It consumes the synchronizer's `out` (stabilised serial data) and `baud` (bit-rate strobe) outputs.
- Samples each bit at the rising edge of `baud`, which is mid-bit because data transitions align with the falling edge.
- Deframes 8N1 frames (optional parity) and delivers bytes through a small FIFO with a valid/ready handshake.
- Reports frame errors, overruns and (optionally) parity errors as single-cycle pulses.

Parameters:
- DATA_BITS, 8, data bits per frame, LSB first; legal range 5..9.
- FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- baud  in  1  bit strobe from synchronizer; one high/low cycle per bit period; rising edge = mid-bit.
- rx  in  1  synchronized serial data (synchronizer `out`); idle high.
- m_data  out  DATA_BITS  head-of-FIFO byte.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  consumer accepts m_data when m_valid && m_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: good frame dropped, FIFO full.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async, rst_n low):
  - Outputs: m_valid=0, m_data=0, frame_err=0, overrun=0, busy=0.
  - Internal: FSM=IDLE, baud_q=0, FIFO pointers=0.
  - Reset mid-frame discards the partial frame. The FIFO is cleared.
- Sample tick:
  - tick = baud && !baud_q, with baud_q registered each clk.
  - All FSM actions occur only on tick cycles, using rx in that cycle.
- FSM states: IDLE, DATA, PARITY, STOP, BREAK.
- IDLE:
  - tick && rx==0: start bit confirmed; go to DATA, bit_cnt=0.
  - tick && rx==1: stay in IDLE.
- DATA:
  - Each tick: shift rx into shreg MSB and right-shift, so the first bit ends at LSB; bit_cnt++.
  - When bit_cnt==DATA_BITS-1 on a tick: go to PARITY if the parity feature is compiled in, else STOP.
- PARITY (feature only): on tick, compare rx with the computed parity, latch the mismatch, go to STOP.
- STOP: on tick:
  - rx==1 and no parity mismatch: push shreg to FIFO next cycle; go to IDLE.
  - rx==0: frame_err pulses next cycle; byte discarded; go to BREAK.
- BREAK: stay until a tick with rx==1, then go to IDLE. A low line never produces spurious bytes.
- Latency: stop tick in cycle N → FIFO write in N+1 → m_valid high in N+2 (FIFO previously empty).
- FIFO:
  - Show-ahead; m_data is valid whenever m_valid=1. m_data holds its value while m_valid && !m_ready.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally. full = MSBs differ and LSBs equal; empty = pointers equal.
  - Push while full with no pop in the same cycle: byte dropped, overrun pulses for 1 cycle, contents unchanged.
  - Push and pop in the same cycle when full: both succeed, no overrun.
  - Push and pop in the same cycle when empty: push only (m_valid was 0).
- frame_err and overrun never assert in the same cycle; a single frame yields exactly one outcome.
- busy=1 in DATA/PARITY/STOP/BREAK.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds the PARITY state and an even-parity check; the parity bit follows the data bits.
  - Adds output port parity_err (1 bit): one-cycle pulse in the cycle after the stop tick, replacing the push; the byte is discarded.
  - If the stop bit is also low, frame_err takes precedence and parity_err stays 0.
- Undefined: no PARITY state, no parity_err port; frame = start + DATA_BITS + stop.

Decomposition:
- Shared package (definitions_pkg): rx_state_e enum (IDLE, DATA, PARITY, STOP, BREAK).
- CLOCK_RATE and BAUD_RATE are already in the package; this block does not use them directly.
- Sub-module uart_rx_fifo (params WIDTH, DEPTH; ports clk, rst_n, wr_en, wr_data, rd_en, rd_data, empty, full). The deframer instantiates it and derives m_valid = !empty.

Test Plan:
- Frame 0x55 (start, 1,0,1,0,1,0,1,0, stop) with m_ready=1 → m_data=0x55, m_valid high exactly 2 clk after stop tick for 1 cycle; busy 0 after.
- Back-to-back 0xA3, 0x0F, 0xFF with no idle gap, m_ready=1 → three bytes in order; no error pulses.
- Stop bit driven low on 0x3C, line held low 3 bit times, then high → one frame_err pulse, no push; FSM in BREAK until the first high tick; next frame 0x12 received correctly.
- m_ready=0, send FIFO_DEPTH+1=5 frames (0x01..0x05) → FIFO holds 0x01..0x04, overrun pulses once on frame 5. Then m_ready=1 → 0x01..0x04 drained in order.
- Assert rst_n low during data bit 4 of 0x77 with 2 bytes queued → m_valid=0 immediately; after release, a fresh frame 0x9A is received alone.
- With UART_RX_PARITY_EN:
  - 0x07 with parity bit 0 (wrong for even parity) → parity_err pulse, no byte.
  - 0x07 with parity bit 1 → m_data=0x07.
